// File: rtl/alu_ctrl_stage.sv
// ID/EX boundary stage: registers ALUop/funct, decodes the 3-bit ALU select,
// supports stall/flush, and flags plus counts illegal decodes.
module alu_ctrl_stage #(
   parameter int          CNT_W  = 8,
   parameter logic [2:0]  OP_ADD = 3'b010
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [1:0]       ALUop,
   input  logic [5:0]       funct,
   input  logic             stall,
   input  logic             flush,
   output logic             in_ready,
   output logic             out_valid,
   output logic [2:0]       op,
   output logic             illegal,
   output logic             err_sticky,
   output logic [CNT_W-1:0] illegal_count
);

   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_SLT = 3'b111;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [2:0] dec_op;
   logic       dec_illegal;
   logic       load;
   logic       accept_illegal;

   assign in_ready = !stall;

   // funct is only examined in the R-type branch, so X on it elsewhere is harmless
   always_comb begin
      dec_op      = OP_ADD;
      dec_illegal = 1'b0;
      case (ALUop)
         2'b00: dec_op = OP_ADD;
         2'b01: dec_op = OP_SUB;
         2'b10: begin
            case (funct)
               FN_ADD:  dec_op = OP_ADD;
               FN_SUB:  dec_op = OP_SUB;
               FN_AND:  dec_op = OP_AND;
               FN_OR:   dec_op = OP_OR;
               FN_SLT:  dec_op = OP_SLT;
               default: dec_illegal = 1'b1;
            endcase
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   assign load           = !flush && !stall;
   assign accept_illegal = load && in_valid && dec_illegal;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid     <= 1'b0;
         op            <= OP_ADD;
         illegal       <= 1'b0;
         err_sticky    <= 1'b0;
         illegal_count <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         op        <= OP_ADD;
         illegal   <= 1'b0;
      end else if (load) begin
         out_valid <= in_valid;
         if (in_valid) begin
            op      <= dec_op;
            illegal <= dec_illegal;
         end else begin
            op      <= OP_ADD;
            illegal <= 1'b0;
         end
         if (accept_illegal) begin
            err_sticky <= 1'b1;
            if (illegal_count != CNT_MAX)
               illegal_count <= illegal_count + CNT_ONE;
         end
      end
   end

endmodule
